mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer that shares one multi-cycle backing memory between the CPU's instruction-fetch side and its data-access side. It grants one requester at a time and holds address, data and control stable on the memory port for the full access latency. It returns read data and a one-cycle completion pulse to the granted side. It sits between the cpu datapath (fetch and load/store logic) and the unified memory, and replaces the separate single-cycle IMEM/DMEM instances.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (D over I) arbiter and sequencer for one multi-cycle memory port.
// Revision: 1.0
`default_nettype none

module mem_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] addr_nxt, wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic        en_nxt, wr_nxt, i_done_nxt, d_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            i_rdata   <= 16'h0000;
            d_rdata   <= 16'h0000;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_en    <= en_nxt;
            mem_wr    <= wr_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            i_done    <= i_done_nxt;
            d_done    <= d_done_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        en_nxt      = mem_en;
        wr_nxt      = mem_wr;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        i_done_nxt  = 1'b0;
        d_done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (d_req) begin
                    state_nxt = D_ACC;
                    cnt_nxt   = CNT_LOAD;
                    en_nxt    = 1'b1;
                    wr_nxt    = d_wr;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                end else if (i_req) begin
                    state_nxt = I_ACC;
                    cnt_nxt   = CNT_LOAD;
                    en_nxt    = 1'b1;
                    wr_nxt    = 1'b0;
                    addr_nxt  = i_addr;
                    wdata_nxt = 16'h0000;
                end
            end
            I_ACC: begin
                if (cnt == 4'd0) begin
                    state_nxt   = DONE;
                    en_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    i_rdata_nxt = mem_rdata;
                    i_done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            D_ACC: begin
                if (cnt == 4'd0) begin
                    state_nxt  = DONE;
                    en_nxt     = 1'b0;
                    wr_nxt     = 1'b0;
                    d_done_nxt = 1'b1;
                    if (!mem_wr) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4 instance for the main sequences, LATENCY=1 for back-to-back fetches.
`default_nettype none

module tb_mem_arbiter;

    typedef struct packed {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        iq[$];
    exp_t        dq[$];

    logic        i_req = 0, d_req = 0, d_wr = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_done, d_done, mem_en, mem_wr, busy;

    logic        i_req1 = 0;
    logic [15:0] i_addr1 = 16'h0010;
    logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_done1, d_done1, mem_en1, mem_wr1, busy1;

    // One-location scratch write buffer over a fixed table is all the sequences need.
    logic        w_vld = 0;
    logic [15:0] w_addr = 0, w_data = 0;

    mem_arbiter #(.LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_rdata(d_rdata1), .d_done(d_done1),
        .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0010: rom = 16'h1234;
            16'h0020: rom = 16'hBEEF;
            16'h0040: rom = 16'h7777;
            16'h0050: rom = 16'h1111;
            16'h0099: rom = 16'h2222;
            16'h0060: rom = 16'hCAFE;
            default:  rom = 16'h0000;
        endcase
    endfunction

    always_comb mem_rdata  = (w_vld && mem_addr == w_addr) ? w_data : rom(mem_addr);
    always_comb mem_rdata1 = mem_addr1 ^ 16'hA5A5;

    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            w_vld  <= 1'b1;
            w_addr <= mem_addr;
            w_data <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation for its side.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && i_done) begin
            if (iq.size() == 0) chk("i_done unexpected", 32'd1, 32'd0);
            else begin
                e = iq.pop_front();
                chk("i_rdata", {16'h0, i_rdata}, {16'h0, e.data});
                chk("i_done cycle", cyc, e.cyc);
            end
        end
        if (rst_n && d_done) begin
            if (dq.size() == 0) chk("d_done unexpected", 32'd1, 32'd0);
            else begin
                e = dq.pop_front();
                chk("d_rdata", {16'h0, d_rdata}, {16'h0, e.data});
                chk("d_done cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        #23;
        chk("reset mem_en", mem_en, 0);
        chk("reset busy", busy, 0);
        chk("reset done", {i_done, d_done}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset rdata", {i_rdata, d_rdata}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Single fetch
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010; c = cyc;
        iq.push_back('{16'h1234, c + 5});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) i_req = 0;
            chk($sformatf("t1 mem_en k%0d", k), mem_en, (k <= 4));
            chk($sformatf("t1 busy k%0d", k), busy, (k <= 5));
            if (k <= 4) chk("t1 mem_addr", {mem_wr, mem_addr}, {1'b0, 16'h0010});
        end

        // Simultaneous requests, D wins
        @(negedge clk);
        i_req = 1; i_addr = 16'h0040; d_req = 1; d_wr = 0; d_addr = 16'h0020; c = cyc;
        dq.push_back('{16'hBEEF, c + 5});
        iq.push_back('{16'h7777, c + 11});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) chk("t2 D granted", mem_addr, 16'h0020);
            if (k == 5) d_req = 0;
            if (k == 6) chk("t2 idle gap", busy, 0);
            if (k == 7) chk("t2 I granted", {mem_en, mem_addr}, {1'b1, 16'h0040});
            if (k == 11) i_req = 0;
        end

        // Write then read back
        @(negedge clk);
        d_req = 1; d_wr = 1; d_addr = 16'h0030; d_wdata = 16'h5A5A; c = cyc;
        dq.push_back('{16'hBEEF, c + 5});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) chk("t3 write strobe", {mem_en, mem_wr, mem_wdata}, {2'b11, 16'h5A5A});
            if (k == 5) begin d_req = 0; d_wr = 0; end
        end
        @(negedge clk);
        d_req = 1; d_wr = 0; d_addr = 16'h0030; c = cyc;
        dq.push_back('{16'h5A5A, c + 5});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) chk("t3 read no strobe", mem_wr, 0);
            if (k == 5) d_req = 0;
        end

        // Inputs change and req drops mid-access
        @(negedge clk);
        d_req = 1; d_addr = 16'h0050; c = cyc;
        dq.push_back('{16'h1111, c + 5});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) begin d_addr = 16'h0099; d_req = 0; end
            if (k <= 4) chk("t4 addr held", mem_addr, 16'h0050);
        end

        // Async reset during I_ACC
        @(negedge clk);
        i_req = 1; i_addr = 16'h0060;
        @(negedge clk); @(negedge clk);
        rst_n = 0; #1;
        chk("t5 reset en/busy", {mem_en, mem_wr, busy}, 0);
        chk("t5 reset rdata", {i_rdata, d_rdata}, 0);
        chk("t5 reset addr", mem_addr, 0);
        i_req = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        i_req = 1; i_addr = 16'h0060; c = cyc;
        iq.push_back('{16'hCAFE, c + 5});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) i_req = 0;
        end

        // LATENCY=1, i_req held: done every 3 cycles
        @(negedge clk);
        i_req1 = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("l1 mem_en k%0d", k), mem_en1, (k % 3 == 1));
            chk($sformatf("l1 i_done k%0d", k), i_done1, (k % 3 == 2));
            if (k % 3 == 2) chk("l1 i_rdata", i_rdata1, 16'hA5B5);
        end
        i_req1 = 0;

        for (int k = 0; k < 20 && (iq.size() + dq.size()) != 0; k++) @(negedge clk);
        chk("scoreboard drained", iq.size() + dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
